// File: rtl/stage_text_sequencer.sv
// Stage text sequencer for the VGA pipeline debug display.
// On a refresh tick it snapshots every stage's instruction and valid bit. It then
// walks the stages one at a time through the shared decoder and streams each
// decoded mnemonic into the text RAM, one stage per row.
module stage_text_sequencer #(
    parameter int NUM_STAGES = 5,
    parameter int STR_CHARS  = 10,
    parameter int COLS       = 80,
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_W     = 12
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      refresh_tick,
    input  logic [32*NUM_STAGES-1:0]  stage_instr,
    input  logic [NUM_STAGES-1:0]     stage_valid,
    output logic [31:0]               dec_instr,
    input  logic [8*STR_CHARS-1:0]    dec_str,
    output logic                      txt_we,
    output logic [ADDR_W-1:0]         txt_addr,
    output logic [7:0]                txt_data,
    input  logic                      txt_ready,
    output logic                      busy,
    output logic                      sweep_done
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int CH_W  = (STR_CHARS > 1) ? $clog2(STR_CHARS) : 1;
    localparam int BUF_W = 8 * STR_CHARS;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(STR_CHARS - 1);
    localparam logic [7:0]       CH_DASH  = 8'h2D;
    localparam logic [7:0]       CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CAPT,
        WRITE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  pending_q, pending_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CH_W-1:0]       c_q, c_d;
    logic [31:0]           dec_instr_q, dec_instr_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [31:0]           shadow_instr_q [NUM_STAGES];
    logic [NUM_STAGES-1:0] shadow_valid_q;
    logic                  snap_en;

    // Row-major text RAM address of (row, column), wrapped to the RAM width.
    function automatic logic [ADDR_W-1:0] write_addr(input logic [IDX_W-1:0] row,
                                                     input logic [CH_W-1:0]  col);
        logic [31:0] full;
        full = 32'(BASE_ADDR) + 32'(row) * 32'(COLS) + 32'(col);
        return full[ADDR_W-1:0];
    endfunction

    // The decoder left-pads short mnemonics with NULs; show those as blanks.
    function automatic logic [7:0] blank_nul(input logic [7:0] ch);
        return (ch == 8'h00) ? CH_SPACE : ch;
    endfunction

    // Next-state logic and write-port outputs; the character buffer shifts left
    // on every accepted write so the outgoing character is always its top byte.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        idx_d       = idx_q;
        c_d         = c_q;
        dec_instr_d = dec_instr_q;
        buf_d       = buf_q;
        snap_en     = 1'b0;
        txt_we      = 1'b0;
        txt_addr    = '0;
        txt_data    = '0;

        // Ticks that arrive mid-sweep (DONE included) collapse into one request.
        if (refresh_tick && (state_q != IDLE)) begin
            pending_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (refresh_tick || pending_q) begin
                    state_d   = LOAD;
                    snap_en   = 1'b1;
                    idx_d     = '0;
                    pending_d = 1'b0;
                end
            end
            LOAD: begin
                dec_instr_d = shadow_instr_q[idx_q];
                state_d     = CAPT;
            end
            CAPT: begin
                buf_d   = shadow_valid_q[idx_q] ? dec_str : {STR_CHARS{CH_DASH}};
                c_d     = '0;
                state_d = WRITE;
            end
            WRITE: begin
                txt_we   = 1'b1;
                txt_addr = write_addr(idx_q, c_q);
                txt_data = blank_nul(buf_q[BUF_W-1 -: 8]);
                if (txt_ready) begin
                    buf_d = buf_q << 8;
                    if (c_q == LAST_CH) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = LOAD;
                        end
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset aborts any sweep and drops a queued request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            idx_q       <= '0;
            c_q         <= '0;
            dec_instr_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            idx_q       <= idx_d;
            c_q         <= c_d;
            dec_instr_q <= dec_instr_d;
        end
    end

    // Data registers: stage snapshot taken at sweep start, and the character buffer.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (snap_en) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                shadow_instr_q[k] <= stage_instr[32*k +: 32];
            end
            shadow_valid_q <= stage_valid;
        end
    end

    assign dec_instr  = dec_instr_q;
    assign busy       = (state_q != IDLE);
    assign sweep_done = (state_q == DONE);

endmodule

// File: tb/tb_stage_text_sequencer.sv
// Bench for stage_text_sequencer: a behavioural decoder drives dec_str, a
// scoreboard queue holds the expected (addr, char) writes of each sweep, and a
// monitor pops and compares them as the text RAM accepts writes.
module tb_stage_text_sequencer;

    localparam int NS = 5;
    localparam int SC = 10;
    localparam int AW = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              refresh_tick;
    logic [32*NS-1:0]  stage_instr;
    logic [NS-1:0]     stage_valid;
    logic [31:0]       dec_instr;
    logic [8*SC-1:0]   dec_str;
    logic              txt_we;
    logic [AW-1:0]     txt_addr;
    logic [7:0]        txt_data;
    logic              txt_ready;
    logic              busy;
    logic              sweep_done;

    always #5 clk = ~clk;

    stage_text_sequencer #(
        .NUM_STAGES(NS), .STR_CHARS(SC), .COLS(80), .BASE_ADDR(0), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .refresh_tick(refresh_tick),
        .stage_instr(stage_instr), .stage_valid(stage_valid),
        .dec_instr(dec_instr), .dec_str(dec_str),
        .txt_we(txt_we), .txt_addr(txt_addr), .txt_data(txt_data),
        .txt_ready(txt_ready), .busy(busy), .sweep_done(sweep_done)
    );

    // Behavioural stand-in for the shared decoder (right-justified, NUL padded).
    function automatic logic [8*SC-1:0] decode(input logic [31:0] i);
        logic [8*SC-1:0] s;
        case (i)
            32'h0000_0013: s = "ADDI";
            32'h0000_0033: s = "ADD";
            32'h4000_0033: s = "SUB";
            default:       s = "UNKNOWN";
        endcase
        return s;
    endfunction

    assign dec_str = decode(dec_instr);

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [32*NS-1:0] ins;
        logic [NS-1:0]    vld;
        int               stall_addr;
        int               stall_len;
        int               exp_done;
    } vec_t;

    wr_t         expq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  mem [0:4095];
    int          cnt84 = 0;
    logic        hold_pend = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [7:0]  hold_data;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic void push_sweep(input logic [32*NS-1:0] ins, input logic [NS-1:0] v);
        for (int k = 0; k < NS; k++) begin
            logic [8*SC-1:0] s;
            s = v[k] ? decode(ins[32*k +: 32]) : {SC{8'h2D}};
            for (int c = 0; c < SC; c++) begin
                wr_t w;
                w.addr = 16'(k*80 + c);
                w.data = s[8*SC-1-8*c -: 8];
                if (w.data == 8'h00) w.data = 8'h20;
                expq.push_back(w);
            end
        end
    endfunction

    // Write monitor: stall stability, scoreboard pop, DONE-cycle write-enable.
    always @(negedge clk) begin
        if (hold_pend && !reset) begin
            check("hold_we", txt_we, 1);
            check("hold_addr", txt_addr, hold_addr);
            check("hold_data", txt_data, hold_data);
        end
        hold_pend = txt_we && !txt_ready;
        hold_addr = txt_addr;
        hold_data = txt_data;
        if (txt_we && txt_ready) begin
            mem[txt_addr] = txt_data;
            if (txt_addr == 12'd84) cnt84++;
            if (expq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: addr %0d data %0h, required no write", txt_addr, txt_data);
            end else begin
                wr_t w;
                w = expq.pop_front();
                check("wr_addr", txt_addr, w.addr[AW-1:0]);
                check("wr_data", txt_data, w.data);
            end
        end
        if (sweep_done) check("we_in_done", txt_we, 0);
    end

    // One sweep (or two with tick_mode): tick, run a fixed cycle window, then check.
    // tick_mode 1: ticks at n=10,20,30; tick_mode 2: a tick in the DONE cycle.
    task automatic sweep(input vec_t v, input int chg_at, input logic [31:0] chg_val,
                         input int tick_mode, input string nm);
        int n, stall_left, done_cnt, first_done, second_done, limit;
        stage_instr = v.ins;
        stage_valid = v.vld;
        txt_ready   = 1'b1;
        push_sweep(v.ins, v.vld);
        if (tick_mode != 0) push_sweep(v.ins, v.vld);
        stall_left  = v.stall_len;
        done_cnt    = 0;
        first_done  = 0;
        second_done = 0;
        limit       = (tick_mode != 0) ? v.exp_done + 62 + 3 : v.exp_done + 3;
        refresh_tick = 1'b1;
        @(posedge clk);
        #1;
        refresh_tick = 1'b0;
        n = 0;
        while (n < limit) begin
            if (txt_we && (int'(txt_addr) == v.stall_addr) && stall_left > 0) begin
                txt_ready = 1'b0;
                stall_left--;
            end else begin
                txt_ready = 1'b1;
            end
            if (n == chg_at) stage_instr[32*4 +: 32] = chg_val;
            refresh_tick = (tick_mode == 1 && (n == 10 || n == 20 || n == 30)) ||
                           (tick_mode == 2 && n == v.exp_done - 1);
            if (tick_mode != 0 && n == v.exp_done) check({nm, "_idle_gap_busy"}, busy, 0);
            if (tick_mode != 0 && n == v.exp_done + 1) check({nm, "_restart_busy"}, busy, 1);
            if (sweep_done) begin
                done_cnt++;
                if (done_cnt == 1) first_done = n + 1;
                if (done_cnt == 2) second_done = n + 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        refresh_tick = 1'b0;
        txt_ready    = 1'b1;
        check({nm, "_done_cycle"}, first_done, v.exp_done);
        if (tick_mode != 0) begin
            check({nm, "_done_count"}, done_cnt, 2);
            check({nm, "_second_done"}, second_done, v.exp_done + 62);
        end else begin
            check({nm, "_done_count"}, done_cnt, 1);
        end
        check({nm, "_busy_after"}, busy, 0);
        check({nm, "_writes_left"}, expq.size(), 0);
        expq.delete();
    endtask

    localparam logic [32*NS-1:0] INS_A =
        {32'h0000_0033, 32'h0000_0033, 32'h0000_0013, 32'h0000_0033, 32'h0000_0013};
    localparam logic [32*NS-1:0] INS_B =
        {32'h0000_0013, 32'hFFFF_FFFF, 32'h4000_0033, 32'h0000_0033, 32'h0000_0033};

    initial begin
        vec_t vecs[6];
        logic [7:0] addi_row [10];
        addi_row = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h41, 8'h44, 8'h44, 8'h49};

        vecs[0] = '{ins: INS_A, vld: 5'b11111, stall_addr: -1,  stall_len: 0, exp_done: 61};
        vecs[1] = '{ins: INS_A, vld: 5'b11011, stall_addr: -1,  stall_len: 0, exp_done: 61};
        vecs[2] = '{ins: INS_A, vld: 5'b11111, stall_addr: 84,  stall_len: 3, exp_done: 64};
        vecs[3] = '{ins: INS_B, vld: 5'b10101, stall_addr: -1,  stall_len: 0, exp_done: 61};
        vecs[4] = '{ins: INS_B, vld: 5'b11111, stall_addr: 0,   stall_len: 1, exp_done: 62};
        vecs[5] = '{ins: INS_A, vld: 5'b00000, stall_addr: 329, stall_len: 2, exp_done: 63};

        reset        = 1'b1;
        refresh_tick = 1'b0;
        stage_instr  = '0;
        stage_valid  = '0;
        txt_ready    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txt_we", txt_we, 0);
        check("rst_txt_addr", txt_addr, 0);
        check("rst_txt_data", txt_data, 0);
        check("rst_dec_instr", dec_instr, 0);
        check("rst_busy", busy, 0);
        check("rst_sweep_done", sweep_done, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            cnt84 = 0;
            sweep(vecs[i], -1, 32'h0, 0, $sformatf("vec%0d", i));
            if (i == 0) begin
                for (int c = 0; c < SC; c++) check($sformatf("addi_char%0d", c), mem[c], addi_row[c]);
            end
            if (i == 1) begin
                for (int c = 0; c < SC; c++) check($sformatf("row2_dash%0d", c), mem[160+c], 8'h2D);
                check("row3_tail", {mem[247], mem[248], mem[249]}, 24'h414444);
            end
            if (i == 2) check("stall_single_write84", cnt84, 1);
        end

        // Stage 4 changes mid-sweep; the snapshot keeps ADD, the next sweep shows SUB.
        sweep(vecs[0], 5, 32'h4000_0033, 0, "snap1");
        check("snap1_row4", {mem[327], mem[328], mem[329]}, 24'h414444);
        vecs[0].ins[32*4 +: 32] = 32'h4000_0033;
        sweep(vecs[0], -1, 32'h0, 0, "snap2");
        check("snap2_row4", {mem[327], mem[328], mem[329]}, 24'h535542);

        // Three ticks during a sweep give exactly one more sweep; so does one tick in DONE.
        sweep(vecs[3], -1, 32'h0, 1, "pend3");
        sweep(vecs[3], -1, 32'h0, 2, "penddone");

        // Reset during stage 2 WRITE, with a request already queued.
        stage_instr  = INS_A;
        stage_valid  = 5'b11111;
        txt_ready    = 1'b1;
        push_sweep(INS_A, 5'b11111);
        refresh_tick = 1'b1;
        @(posedge clk);
        #1;
        refresh_tick = 1'b0;
        for (int n = 0; n < 28; n++) begin
            refresh_tick = (n == 10);
            @(posedge clk);
            #1;
        end
        refresh_tick = 1'b0;
        check("rstmid_in_row2_we", txt_we, 1);
        check("rstmid_in_row2_addr", txt_addr, 162);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid_we", txt_we, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_done", sweep_done, 0);
        check("rstmid_dec_instr", dec_instr, 0);
        expq.delete();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rstmid_pending_cleared", busy, 0);
        sweep(vecs[1], -1, 32'h0, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
